canvas_write_ctrl: RTL

- Sequences all writes into the 320x240x12 canvas frame buffer (single-port block RAM, 76800 words).
- Shares the buffer write port between two sources:
  - a full-canvas clear sweep, triggered at reset release or by a user clear pulse;
  - brush paint requests at the mouse position from the drawing logic.
- Sits between the mouse/colour-select logic and the frame buffer's write-enable, address and data pins.
- The VGA scan owns the address pin whenever this block is not busy.

---
 rtl/canvas_write_ctrl_if.sv | 25 ++
 rtl/canvas_write_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/canvas_write_ctrl_if.sv
// Write-side bundle between the drawing logic and the canvas frame-buffer sequencer.
// The drawing/mouse side is the master; the sequencer is the slave.
interface canvas_write_ctrl_if;
  logic        clear_req;
  logic        paint_req;
  logic [9:0]  paint_x;
  logic [9:0]  paint_y;
  logic [11:0] paint_color;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        paint_ack;
  logic        clear_done;

  modport master (
    output clear_req, paint_req, paint_x, paint_y, paint_color,
    input  wr_en, wr_addr, wr_data, busy, paint_ack, clear_done
  );

  modport slave (
    input  clear_req, paint_req, paint_x, paint_y, paint_color,
    output wr_en, wr_addr, wr_data, busy, paint_ack, clear_done
  );
endinterface

// File: rtl/canvas_write_ctrl.sv
// Canvas frame-buffer write sequencer: shares the single buffer write port
// between a full-canvas clear sweep and BRUSH x BRUSH paint requests.
module canvas_write_ctrl #(
  parameter int unsigned FB_W           = 320,
  parameter int unsigned FB_H           = 240,
  parameter logic [11:0] CLEAR_COLOR    = 12'hFFF,
  parameter int unsigned BRUSH          = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic               clk,
  input logic               rst,
  canvas_write_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | VGA scan owns the buffer address; waiting for clear or paint
  // CLEAR | writing CLEAR_COLOR to every buffer word, one per cycle
  // PAINT | stepping row-major through the brush square at the latched point
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_PAINT = 2'd2
  } state_e;

  localparam int unsigned NPIX      = FB_W * FB_H;
  localparam logic [16:0] LAST_ADDR = 17'(NPIX - 1);
  localparam logic [3:0]  BR_LAST   = 4'(BRUSH - 1);
  localparam logic [3:0]  BR_END    = 4'(BRUSH);

  state_e      state_q, state_d;
  logic        clear_pending_q, clear_pending_d;
  logic [8:0]  fx_q, fx_d;
  logic [8:0]  fy_q, fy_d;
  logic [11:0] color_q, color_d;
  logic [3:0]  dx_q, dx_d;
  logic [3:0]  dy_q, dy_d;

  logic        wr_en_q, wr_en_d;
  logic [16:0] wr_addr_q, wr_addr_d;
  logic [11:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        paint_ack_q, paint_ack_d;
  logic        clear_done_q, clear_done_d;

  logic        start_clear;
  logic        paint_take;
  logic        paint_off;
  logic        clear_last;
  logic        paint_end;
  logic        cand_ok;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [16:0] cand_addr;

  // The held request is ignored during its own ack cycle so it is not taken twice.
  always_comb begin
    start_clear = bus.clear_req | clear_pending_q;
    paint_take  = bus.paint_req & ~paint_ack_q;
    paint_off   = (bus.paint_x >= 10'd640) | (bus.paint_y >= 10'd480);
    clear_last  = (wr_addr_q == LAST_ADDR);
    paint_end   = (dy_q == BR_END);
    cx          = {1'b0, fx_q} + {6'd0, dx_q};
    cy          = {1'b0, fy_q} + {6'd0, dy_q};
    cand_ok     = (32'(cx) < FB_W) && (32'(cy) < FB_H);
    cand_addr   = 17'(cy) * 17'(FB_W) + 17'(cx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      clear_pending_q <= CLEAR_ON_RESET;
      fx_q            <= '0;
      fy_q            <= '0;
      color_q         <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      busy_q          <= 1'b0;
      paint_ack_q     <= 1'b0;
      clear_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      fx_q            <= fx_d;
      fy_q            <= fy_d;
      color_q         <= color_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      busy_q          <= busy_d;
      paint_ack_q     <= paint_ack_d;
      clear_done_q    <= clear_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    fx_d            = fx_q;
    fy_d            = fy_q;
    color_d         = color_q;
    dx_d            = dx_q;
    dy_d            = dy_q;
    case (state_q)
      S_IDLE: begin
        if (start_clear) begin
          state_d         = S_CLEAR;
          clear_pending_d = 1'b0;
        end else if (paint_take) begin
          fx_d    = bus.paint_x[9:1];
          fy_d    = bus.paint_y[9:1];
          color_d = bus.paint_color;
          dx_d    = '0;
          dy_d    = '0;
          if (!paint_off) state_d = S_PAINT;
        end
      end
      S_CLEAR: begin
        if (clear_last) state_d = S_IDLE;
      end
      S_PAINT: begin
        // A clear arriving mid-paint waits until the brush square is finished.
        if (bus.clear_req) clear_pending_d = 1'b1;
        if (paint_end) begin
          state_d = S_IDLE;
        end else if (dx_q == BR_LAST) begin
          dx_d = '0;
          dy_d = dy_q + 4'd1;
        end else begin
          dx_d = dx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = 1'b0;
    paint_ack_d  = 1'b0;
    clear_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_clear) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = CLEAR_COLOR;
          busy_d    = 1'b1;
        end else if (paint_take) begin
          busy_d      = ~paint_off;
          paint_ack_d = paint_off;
        end
      end
      S_CLEAR: begin
        if (clear_last) begin
          clear_done_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 17'd1;
          wr_data_d = CLEAR_COLOR;
          busy_d    = 1'b1;
        end
      end
      S_PAINT: begin
        if (paint_end) begin
          paint_ack_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          // Off-canvas slots still take their cycle so paint latency stays fixed.
          if (cand_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cand_addr;
            wr_data_d = color_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.paint_ack  = paint_ack_q;
  assign bus.clear_done = clear_done_q;
endmodule
